// File: rtl/accumulator_drain_unit_pkg.sv
// Shared TPU constants and the drain FSM state type for the accumulator drain unit.
package tpu_package;

   localparam int MUL_SIZE  = 32;
   localparam int ACC_WIDTH = 32;
   localparam int OUT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      FLUSH,
      DONE
   } drain_state_t;

endpackage : tpu_package

// File: rtl/accumulator_drain_unit_if.sv
// Accumulator read port and unified buffer write port of the drain unit.
interface accumulator_drain_unit_if #(
   parameter int MUL_SIZE   = tpu_package::MUL_SIZE,
   parameter int ACC_WIDTH  = tpu_package::ACC_WIDTH,
   parameter int OUT_WIDTH  = tpu_package::OUT_WIDTH,
   parameter int ACC_ADDR_W = 7,
   parameter int UB_ADDR_W  = 12
);

   logic                          acc_rd_en_o;
   logic [ACC_ADDR_W-1:0]         acc_rd_addr_o;
   logic [MUL_SIZE*ACC_WIDTH-1:0] acc_rd_data_i;
   logic                          ub_wr_en_o;
   logic                          ub_wr_ready_i;
   logic [UB_ADDR_W-1:0]          ub_wr_addr_o;
   logic [MUL_SIZE*OUT_WIDTH-1:0] ub_wr_data_o;

   modport master (
      output acc_rd_en_o, acc_rd_addr_o,
      input  acc_rd_data_i,
      output ub_wr_en_o, ub_wr_addr_o, ub_wr_data_o,
      input  ub_wr_ready_i
   );

   modport slave (
      input  acc_rd_en_o, acc_rd_addr_o,
      output acc_rd_data_i,
      input  ub_wr_en_o, ub_wr_addr_o, ub_wr_data_o,
      output ub_wr_ready_i
   );

endinterface : accumulator_drain_unit_if

// File: rtl/accumulator_drain_unit_requant_lane.sv
// One requant lane: arithmetic shift with round-half-up, int8 saturation.
// ACCUM_DRAIN_RELU_EN defined: negative saturated results are clamped to zero.
module accum_requant_lane #(
   parameter int ACC_WIDTH = tpu_package::ACC_WIDTH,
   parameter int OUT_WIDTH = tpu_package::OUT_WIDTH
) (
   input  logic [ACC_WIDTH-1:0] acc_i,
   input  logic [4:0]           shift_i,
   output logic [OUT_WIDTH-1:0] out_o
);

   localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'((2**(OUT_WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH:0] SAT_LO = ~SAT_HI;

   logic signed [ACC_WIDTH:0] ext;
   logic signed [ACC_WIDTH:0] rnd;
   logic signed [ACC_WIDTH:0] sum;
   logic signed [ACC_WIDTH:0] shifted;
   logic        [OUT_WIDTH-1:0] sat;

   // One extra bit keeps acc + rounding constant from overflowing.
   always_comb begin
      ext = {acc_i[ACC_WIDTH-1], acc_i};
      rnd = '0;
      if (shift_i != '0) begin
         rnd = (ACC_WIDTH+1)'(1) << (shift_i - 5'd1);
      end
      sum     = ext + rnd;
      shifted = sum >>> shift_i;
      if (shifted > SAT_HI) begin
         sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else if (shifted < SAT_LO) begin
         sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         sat = shifted[OUT_WIDTH-1:0];
      end
`ifdef ACCUM_DRAIN_RELU_EN
      if (sat[OUT_WIDTH-1]) begin
         sat = '0;
      end
`endif
      out_o = sat;
   end

endmodule : accum_requant_lane

// File: rtl/accumulator_drain_unit.sv
// Drains accumulator rows, requantizes each lane and writes packed rows to the unified buffer.
// ACCUM_DRAIN_RELU_EN (optional define) fuses a ReLU into every requant lane.
module accumulator_drain_unit #(
   parameter int MUL_SIZE   = tpu_package::MUL_SIZE,
   parameter int ACC_WIDTH  = tpu_package::ACC_WIDTH,
   parameter int OUT_WIDTH  = tpu_package::OUT_WIDTH,
   parameter int ACC_ADDR_W = 7,
   parameter int UB_ADDR_W  = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [8:0]            num_rows_i,
   input  logic [ACC_ADDR_W-1:0] acc_base_addr_i,
   input  logic [UB_ADDR_W-1:0]  ub_base_addr_i,
   input  logic [4:0]            shift_i,
   output logic                  busy_o,
   output logic                  done_o,
   accumulator_drain_unit_if.master bus
);

   import tpu_package::*;

   localparam int OUT_ROW_W = MUL_SIZE * OUT_WIDTH;

   drain_state_t state_q, state_d;

   logic [8:0]            num_rows_q;
   logic [8:0]            rd_cnt_q;
   logic [8:0]            wr_cnt_q;
   logic [ACC_ADDR_W-1:0] acc_base_q;
   logic [UB_ADDR_W-1:0]  ub_base_q;
   logic [4:0]            shift_q;
   logic                  rd_pend_q;

   logic [OUT_ROW_W-1:0]  fifo_mem_q [2];
   logic [1:0]            fifo_cnt_q;
   logic                  fifo_rd_ptr_q;
   logic                  fifo_wr_ptr_q;

   logic [OUT_ROW_W-1:0]  req_row;
   logic                  start_acc;
   logic                  rd_issue;
   logic                  wr_fire;
   logic                  fifo_push;
   logic [1:0]            occ_after;

   for (genvar g = 0; g < MUL_SIZE; g++) begin : g_lane
      accum_requant_lane #(
         .ACC_WIDTH (ACC_WIDTH),
         .OUT_WIDTH (OUT_WIDTH)
      ) u_lane (
         .acc_i   (bus.acc_rd_data_i[g*ACC_WIDTH +: ACC_WIDTH]),
         .shift_i (shift_q),
         .out_o   (req_row[g*OUT_WIDTH +: OUT_WIDTH])
      );
   end

   assign wr_fire   = (fifo_cnt_q != 2'd0) && bus.ub_wr_ready_i;
   assign fifo_push = rd_pend_q;
   // Occupancy once this cycle's landing row and pop settle; a same-cycle pop
   // frees a slot so reads can stream at one row per cycle.
   assign occ_after = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, wr_fire};

   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      rd_issue  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               state_d   = (num_rows_i == 9'd0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (occ_after < 2'd2) begin
               rd_issue = 1'b1;
               if (rd_cnt_q == num_rows_q - 9'd1) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (wr_cnt_q == num_rows_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         num_rows_q <= '0;
         acc_base_q <= '0;
         ub_base_q  <= '0;
         shift_q    <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         rd_pend_q  <= 1'b0;
      end else begin
         rd_pend_q <= rd_issue;
         if (start_acc) begin
            num_rows_q <= num_rows_i;
            acc_base_q <= acc_base_addr_i;
            ub_base_q  <= ub_base_addr_i;
            shift_q    <= shift_i;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
         end else begin
            if (rd_issue) begin
               rd_cnt_q <= rd_cnt_q + 9'd1;
            end
            if (wr_fire) begin
               wr_cnt_q <= wr_cnt_q + 9'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
         fifo_cnt_q    <= '0;
         fifo_rd_ptr_q <= 1'b0;
         fifo_wr_ptr_q <= 1'b0;
      end else begin
         if (fifo_push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= req_row;
            fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
         end
         if (wr_fire) begin
            fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
         end
         fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, wr_fire};
      end
   end

   assign bus.acc_rd_en_o   = rd_issue;
   assign bus.acc_rd_addr_o = acc_base_q + ACC_ADDR_W'(rd_cnt_q);
   assign bus.ub_wr_en_o    = (fifo_cnt_q != 2'd0);
   assign bus.ub_wr_addr_o  = ub_base_q + UB_ADDR_W'(wr_cnt_q);
   assign bus.ub_wr_data_o  = fifo_mem_q[fifo_rd_ptr_q];

   assign busy_o = (state_q == DRAIN) || (state_q == FLUSH);
   assign done_o = (state_q == DONE);

endmodule : accumulator_drain_unit

// File: tb/tb_accumulator_drain_unit.sv
// Directed scoreboard bench for accumulator_drain_unit; honours ACCUM_DRAIN_RELU_EN.
module tb_accumulator_drain_unit;

   import tpu_package::*;

   localparam int ACC_ADDR_W = 7;
   localparam int UB_ADDR_W  = 12;
   localparam int ROW_W      = MUL_SIZE * ACC_WIDTH;
   localparam int OUT_ROW_W  = MUL_SIZE * OUT_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst_i;
   logic                  start_i;
   logic [8:0]            num_rows_i;
   logic [ACC_ADDR_W-1:0] acc_base_addr_i;
   logic [UB_ADDR_W-1:0]  ub_base_addr_i;
   logic [4:0]            shift_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  ready;
   logic [ROW_W-1:0]      rd_q;

   logic [ROW_W-1:0]      acc_mem [128];

   int n_pass  = 0;
   int n_total = 0;

   int              exp_rd_q [$];
   int              exp_wa_q [$];
   logic [255:0]    exp_wd_q [$];

   always #5 clk = ~clk;

   accumulator_drain_unit_if bus ();

   accumulator_drain_unit dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .num_rows_i      (num_rows_i),
      .acc_base_addr_i (acc_base_addr_i),
      .ub_base_addr_i  (ub_base_addr_i),
      .shift_i         (shift_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .bus             (bus)
   );

   // Accumulator memory model: one cycle read latency.
   always @(posedge clk) begin
      if (bus.acc_rd_en_o) rd_q <= acc_mem[bus.acc_rd_addr_o];
   end
   assign bus.acc_rd_data_i = rd_q;
   assign bus.ub_wr_ready_i = ready;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] req_lane(input logic signed [31:0] a, input int sh);
      longint v;
      v = a;
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
`ifdef ACCUM_DRAIN_RELU_EN
      if (v < 0) v = 0;
`endif
      return v[7:0];
   endfunction

   function automatic logic [255:0] model_row(input int a, input int sh);
      logic [255:0] r;
      logic [ROW_W-1:0] src;
      r = '0;
      src = acc_mem[a];
      for (int i = 0; i < MUL_SIZE; i++) r[i*8 +: 8] = req_lane(src[i*32 +: 32], sh);
      return r;
   endfunction

   task automatic plan_rows(input int rows, input int acc_b, input int ub_b, input int sh);
      for (int r = 0; r < rows; r++) begin
         exp_rd_q.push_back((acc_b + r) % 128);
         exp_wa_q.push_back((ub_b + r) % 4096);
         exp_wd_q.push_back(model_row((acc_b + r) % 128, sh));
      end
   endtask

   task automatic run_drain(input int rows, input int acc_b, input int ub_b, input int sh,
                            input int pat, input int poke_cyc, input int abort_cyc);
      int cyc = 0, rd_seen = 0, wr_seen = 0, outst = 0, max_out = 0, done_cyc = -1;
      bit prev_stall = 1'b0, fin = 1'b0;
      logic [UB_ADDR_W-1:0] pa;
      logic [255:0] pd;
      @(negedge clk);
      num_rows_i = 9'(rows); acc_base_addr_i = 7'(acc_b); ub_base_addr_i = 12'(ub_b);
      shift_i = 5'(sh); start_i = 1'b1; ready = 1'b1;
      @(negedge clk);
      num_rows_i = 9'd3; acc_base_addr_i = 7'($urandom); ub_base_addr_i = 12'($urandom);
      shift_i = 5'($urandom);
      while (!fin && cyc < 200) begin
         start_i = (cyc == poke_cyc);
         ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         #1;
         if (bus.acc_rd_en_o) begin
            rd_seen++; outst++;
            if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
            else check("rd_addr", 256'(bus.acc_rd_addr_o), 256'(exp_rd_q.pop_front()));
         end
         if (prev_stall) begin
            check("stall_en", 256'(bus.ub_wr_en_o), 1);
            check("stall_addr", 256'(bus.ub_wr_addr_o), 256'(pa));
            check("stall_data", bus.ub_wr_data_o, pd);
         end
         if (bus.ub_wr_en_o && ready) begin
            wr_seen++; outst--;
            if (exp_wa_q.size() == 0) check("wr_extra", 1, 0);
            else begin
               check("wr_addr", 256'(bus.ub_wr_addr_o), 256'(exp_wa_q.pop_front()));
               check("wr_data", bus.ub_wr_data_o, exp_wd_q.pop_front());
            end
         end
         prev_stall = bus.ub_wr_en_o && !ready;
         pa = bus.ub_wr_addr_o;
         pd = bus.ub_wr_data_o;
         if (outst > max_out) max_out = outst;
         if (done_o) begin
            done_cyc = cyc; fin = 1'b1;
            check("busy_at_done", 256'(busy_o), 0);
         end
         if (cyc == abort_cyc) begin
            #2 rst_i = 1'b0;
            #1;
            check("abort_rd_en", 256'(bus.acc_rd_en_o), 0);
            check("abort_wr_en", 256'(bus.ub_wr_en_o), 0);
            check("abort_busy", 256'(busy_o), 0);
            check("abort_wr_data", bus.ub_wr_data_o, 0);
            check("abort_wr_addr", 256'(bus.ub_wr_addr_o), 0);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk); #1;
               check("abort_no_done", 256'(done_o), 0);
            end
            @(negedge clk);
            rst_i = 1'b1; start_i = 1'b0;
            exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
            return;
         end
         cyc++;
         @(negedge clk);
      end
      start_i = 1'b0;
      check("drain_timeout", 256'(fin), 1);
      #1;
      check("done_one_cycle", 256'(done_o), 0);
      check("rd_count", 256'(rd_seen), 256'(rows));
      check("wr_count", 256'(wr_seen), 256'(rows));
      check("max_outstanding_le2", 256'(max_out <= 2), 1);
      check("queue_drained", 256'(exp_wa_q.size() + exp_rd_q.size()), 0);
      if (rows == 0) check("zero_rows_done_cyc", 256'(done_cyc), 0);
   endtask

   initial begin
      logic signed [31:0] t;
      logic [255:0] e;
      rst_i = 1'b0; start_i = 1'b0; ready = 1'b1;
      num_rows_i = '0; acc_base_addr_i = '0; ub_base_addr_i = '0; shift_i = '0;
      for (int r = 0; r < 128; r++) begin
         for (int i = 0; i < MUL_SIZE; i++) begin
            t = $urandom;
            t = t >>> $urandom_range(0, 28);
            acc_mem[r][i*32 +: 32] = t;
         end
      end
      repeat (3) @(negedge clk);
      #1;
      check("rst_rd_en", 256'(bus.acc_rd_en_o), 0);
      check("rst_wr_en", 256'(bus.ub_wr_en_o), 0);
      check("rst_busy", 256'(busy_o), 0);
      check("rst_done", 256'(done_o), 0);
      check("rst_wr_data", bus.ub_wr_data_o, 0);
      check("rst_wr_addr", 256'(bus.ub_wr_addr_o), 0);
      check("rst_rd_addr", 256'(bus.acc_rd_addr_o), 0);
      rst_i = 1'b1;

      // lanes hold their index, shift 0
      e = '0;
      for (int i = 0; i < MUL_SIZE; i++) e[i*8 +: 8] = 8'(i);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < MUL_SIZE; i++) acc_mem[r][i*32 +: 32] = i;
         exp_rd_q.push_back(r);
         exp_wa_q.push_back('h100 + r);
         exp_wd_q.push_back(e);
      end
      run_drain(4, 0, 'h100, 0, 0, -1, -1);

      // rounding and saturation corners at shift 4
      acc_mem[40] = '0;
      acc_mem[40][0*32 +: 32] = 23;
      acc_mem[40][1*32 +: 32] = -24;
      acc_mem[40][2*32 +: 32] = 24;
      acc_mem[40][3*32 +: 32] = 100000;
      acc_mem[40][4*32 +: 32] = -100000;
      e = '0;
      e[7:0] = 8'd1;
      e[23:16] = 8'd2;
      e[31:24] = 8'd127;
`ifdef ACCUM_DRAIN_RELU_EN
      e[15:8] = 8'h00;
      e[39:32] = 8'h00;
`else
      e[15:8] = 8'hFF;
      e[39:32] = 8'h80;
`endif
      exp_rd_q.push_back(40); exp_wa_q.push_back('h200); exp_wd_q.push_back(e);
      run_drain(1, 40, 'h200, 4, 0, -1, -1);

      plan_rows(3, 50, 'h300, 1);  run_drain(3, 50, 'h300, 1, 0, -1, -1);
      plan_rows(3, 60, 'h310, 16); run_drain(3, 60, 'h310, 16, 0, -1, -1);
      plan_rows(3, 70, 'h320, 31); run_drain(3, 70, 'h320, 31, 0, -1, -1);

      // backpressure pattern 1,0,0,1
      plan_rows(8, 10, 'h20, 3);
      run_drain(8, 10, 'h20, 3, 1, -1, -1);

      // both address counters wrap
      plan_rows(4, 126, 'hFFF, 5);
      run_drain(4, 126, 'hFFF, 5, 0, -1, -1);

      // zero rows, then a start pulse while busy
      run_drain(0, 5, 5, 0, 0, -1, -1);
      plan_rows(4, 80, 'h400, 2);
      run_drain(4, 80, 'h400, 2, 0, 2, -1);

      // reset mid-drain, then a clean drain
      plan_rows(16, 90, 'h500, 6);
      run_drain(16, 90, 'h500, 6, 0, -1, 6);
      plan_rows(3, 20, 'h600, 2);
      run_drain(3, 20, 'h600, 2, 1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_accumulator_drain_unit
